// File: rtl/modulo_divisor_if.sv
// Start/busy/done handshake bundle between the arithmetic-unit control and the divider.
interface modulo_divisor_if;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] quociente;
  logic [7:0] resto;
  logic       div_zero;

  modport master (
    output start, a, b,
    input  busy, done, quociente, resto, div_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, quociente, resto, div_zero
  );
endinterface

// File: rtl/modulo_divisor.sv
// Iterative unsigned 8-bit restoring divider: one quotient bit per cycle, results
// held until the next completion, divide-by-zero answered directly from IDLE.
module modulo_divisor (
  input logic              clk,
  input logic              reset,
  modulo_divisor_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [7:0]  dividend_r;
  logic [7:0]  divisor_r;
  logic [7:0]  partial_r;
  logic [7:0]  quot_r;
  logic [2:0]  count_r;
  logic        done_r;
  logic [7:0]  quociente_r;
  logic [7:0]  resto_r;
  logic        div_zero_r;
  logic [8:0]  shifted_s;
  logic        ge_s;
  logic [7:0]  diff_s;

  // One restoring step plus next-state selection.
  always_comb begin
    shifted_s    = {partial_r, dividend_r[7]};
    ge_s         = (shifted_s >= {1'b0, divisor_r});
    // Result is below the divisor, so the low 8 bits of the difference are exact.
    if (ge_s) begin
      diff_s = shifted_s[7:0] - divisor_r;
    end else begin
      diff_s = shifted_s[7:0];
    end
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start && (bus.b != 8'd0)) begin
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (count_r == 3'd7) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = CALC;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture, iteration registers and held result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dividend_r  <= 8'd0;
      divisor_r   <= 8'd0;
      partial_r   <= 8'd0;
      quot_r      <= 8'd0;
      count_r     <= 3'd0;
      done_r      <= 1'b0;
      quociente_r <= 8'd0;
      resto_r     <= 8'd0;
      div_zero_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start && (bus.b != 8'd0)) begin
            dividend_r <= bus.a;
            divisor_r  <= bus.b;
            partial_r  <= 8'd0;
            quot_r     <= 8'd0;
            count_r    <= 3'd0;
          end else if (bus.start) begin
            quociente_r <= 8'hFF;
            resto_r     <= bus.a;
            div_zero_r  <= 1'b1;
            done_r      <= 1'b1;
          end else begin
            count_r <= 3'd0;
          end
        end
        CALC: begin
          partial_r  <= diff_s;
          dividend_r <= {dividend_r[6:0], 1'b0};
          quot_r     <= {quot_r[6:0], ge_s};
          count_r    <= count_r + 3'd1;
          if (count_r == 3'd7) begin
            quociente_r <= {quot_r[6:0], ge_s};
            resto_r     <= diff_s;
            div_zero_r  <= 1'b0;
            done_r      <= 1'b1;
          end else begin
            done_r <= 1'b0;
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = (state_r == CALC);
  assign bus.done      = done_r;
  assign bus.quociente = quociente_r;
  assign bus.resto     = resto_r;
  assign bus.div_zero  = div_zero_r;

endmodule

// File: tb/tb_modulo_divisor.sv
// Directed and randomized checks of modulo_divisor against a quotient/remainder scoreboard.
module tb_modulo_divisor;

  logic clk;
  logic reset;
  modulo_divisor_if bus ();

  modulo_divisor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   busy_cycles = 0;
  int   done_cnt = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 8'd0) begin
      e.q = 8'hFF; e.r = a; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Advance to the next falling edge and score any completion seen there.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (bus.busy === 1'b1) busy_cycles++;
    if (bus.done === 1'b1) begin
      done_cnt++;
      chk("done_not_busy", {15'd0, bus.busy}, 16'd0);
      chk("done_expected", 16'(sb.size() != 0), 16'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("quociente", {8'd0, bus.quociente}, {8'd0, e.q});
        chk("resto",     {8'd0, bus.resto},     {8'd0, e.r});
        chk("div_zero",  {15'd0, bus.div_zero}, {15'd0, e.dz});
      end
    end
  endtask

  task automatic do_div(input logic [7:0] a, input logic [7:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    push(a, b);
    busy_cycles = 0;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      step();
      n++;
    end
    chk("wait_timeout", 16'(sb.size()), 16'd0);
    sb.delete();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"},  {15'd0, bus.busy},      16'd0);
    chk({tag, "_done"},  {15'd0, bus.done},      16'd0);
    chk({tag, "_quo"},   {8'd0, bus.quociente},  16'd0);
    chk({tag, "_res"},   {8'd0, bus.resto},      16'd0);
    chk({tag, "_dz"},    {15'd0, bus.div_zero},  16'd0);
  endtask

  initial begin
    int d0;
    logic [7:0] ra;
    logic [7:0] rb;
    int n;

    bus.start = 1'b0;
    bus.a     = 8'd0;
    bus.b     = 8'd0;
    reset     = 1'b1;
    step();
    step();
    chk_zero_outputs("reset");
    reset = 1'b0;

    // 100 / 7: eight busy cycles, single done pulse
    do_div(8'd100, 8'd7);
    wait_done(20);
    chk("busy_len_100_7", 16'(busy_cycles), 16'd8);
    step();
    chk("done_one_cycle", {15'd0, bus.done}, 16'd0);

    do_div(8'd255, 8'd1); wait_done(20);
    do_div(8'd5,   8'd9); wait_done(20);
    do_div(8'd0,   8'd3); wait_done(20);

    // divide by zero answers on the next edge without going busy
    do_div(8'd200, 8'd0);
    chk("div0_latency", 16'(sb.size()), 16'd0);
    chk("div0_no_busy", 16'(busy_cycles), 16'd0);
    step();
    chk("div0_held_dz", {15'd0, bus.div_zero}, 16'd1);
    do_div(8'd9, 8'd3); wait_done(20);

    // start and operand changes during CALC are ignored
    d0 = done_cnt;
    do_div(8'd100, 8'd7);
    step(); step();
    bus.start = 1'b1; bus.a = 8'd55; bus.b = 8'd0;
    step(); step();
    bus.start = 1'b0; bus.a = 8'd1; bus.b = 8'd1;
    wait_done(20);
    for (int i = 0; i < 12; i++) step();
    chk("ignore_single_done", 16'(done_cnt - d0), 16'd1);

    // reset during the fourth CALC cycle
    do_div(8'd100, 8'd7);
    step(); step(); step();
    reset = 1'b1;
    sb.delete();
    step();
    reset = 1'b0;
    chk_zero_outputs("midreset");
    do_div(8'd100, 8'd7);
    wait_done(20);
    chk("busy_len_after_reset", 16'(busy_cycles), 16'd8);

    // start held high: random pairs, 9-cycle spacing for b!=0, 1 for b=0
    bus.start = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      ra = 8'($urandom_range(0, 255));
      case (i % 50)
        0:       rb = 8'd0;
        1:       rb = 8'd1;
        2:       rb = 8'd255;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      if (i == 3) ra = 8'd255;
      bus.a = ra;
      bus.b = rb;
      push(ra, rb);
      n = (rb == 8'd0) ? 1 : 9;
      for (int j = 0; j < n - 1; j++) step();
      chk("sweep_not_early", 16'(sb.size()), 16'd1);
      step();
      chk("sweep_spacing", 16'(sb.size()), 16'd0);
      sb.delete();
    end
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("final_idle", {15'd0, bus.busy}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
